// File: rtl/sram_like_responder_pkg.sv
// sram_like_responder_pkg
//   Shared definitions for the SRAM-like responder: size encodings, the
//   response-entry layout, the LFSR seed and small datapath helpers.
//   Optional feature macro used by the top: SRAM_RAND_DELAY_EN.
package sram_like_responder_pkg;

  // Transfer size encodings carried on the size port (informational only).
  localparam logic [1:0] SRAM_SIZE_B = 2'd0;
  localparam logic [1:0] SRAM_SIZE_H = 2'd1;
  localparam logic [1:0] SRAM_SIZE_W = 2'd2;

  // One response entry: {is_read, data}.
  localparam int RESP_ENTRY_W = 33;

  // Reset value of the optional stall-injection LFSR.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } resp_entry_t;

  // Merge lane-aligned write data into an existing word under byte strobes.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// sram_like_responder_resp_fifo
//   Synchronous FIFO holding accepted-but-unanswered responses in order.
//   Pointers wrap modulo DEPTH, so DEPTH need not fill the pointer range.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write one entry (ignored when full)
//   pop             retire the head entry (ignored when empty)
//   head            current head entry
//   count           number of stored entries
//   full, empty     status flags derived from count
module sram_like_responder_resp_fifo
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = RESP_ENTRY_W,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [W-1:0]  store_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == {CW{1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = store_r[rd_ptr_r];
  assign count   = count_r;

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder
//   Responder end of the SRAM-like req/addr_ok/data_ok bus. Holds a
//   word-addressed memory, accepts pipelined requests while the response
//   FIFO has room, and returns one response per cycle in acceptance order.
//   Optional macro SRAM_RAND_DELAY_EN: an LFSR randomly withholds addr_ok
//   (lfsr[0]) and data_ok (lfsr[1]) to exercise requester stall paths.
// Ports:
//   clk, rst   clock, synchronous active-high reset (memory contents kept)
//   req, wr    request valid, 1=write 0=read
//   size       transfer size, informational only (wstrb is authoritative)
//   wstrb      byte-lane write enables
//   addr       byte address, word index = addr[MEM_AW+1:2], upper bits alias
//   wdata      lane-aligned write data
//   addr_ok    request accepted this cycle when req is also high
//   data_ok    one response retired this cycle
//   rdata      head read data while data_ok, else 0
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int MEM_AW   = 12,
  parameter int OUTSTAND = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int CW    = $clog2(OUTSTAND + 1);

  logic [31:0]       mem [DEPTH];
  logic [MEM_AW-1:0] idx;
  logic              handshake;
  logic              gate_accept;
  logic              gate_resp;
  resp_entry_t       push_entry;
  resp_entry_t       head_entry;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_bits;

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_r;

  // Stall-injection LFSR, free-running every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign gate_accept = lfsr_r[0];
  assign gate_resp   = lfsr_r[1];
`else
  assign gate_accept = 1'b1;
  assign gate_resp   = 1'b1;
`endif

  assign idx = addr[MEM_AW+1:2];

  // Handshake flags: accept depends only on registered occupancy (no pop
  // bypass when full), and both are forced low during reset.
  always_comb begin
    addr_ok = 1'b0;
    data_ok = 1'b0;
    if (!rst) begin
      addr_ok = !fifo_full && gate_accept;
      data_ok = !fifo_empty && gate_resp;
    end else begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
    end
  end

  assign handshake = req && addr_ok;

  // Build the response entry; a read samples the word before any write at
  // the same edge, and write responses carry zero data.
  always_comb begin
    push_entry = '0;
    if (wr) begin
      push_entry.is_read = 1'b0;
      push_entry.data    = 32'h0000_0000;
    end else begin
      push_entry.is_read = 1'b1;
      push_entry.data    = mem[idx];
    end
  end

  // Memory write port, byte-lane merge at the accepting edge.
  always_ff @(posedge clk) begin
    if (handshake && wr) begin
      mem[idx] <= merge_lanes(mem[idx], wdata, wstrb);
    end
  end

  sram_like_responder_resp_fifo #(
    .DEPTH (OUTSTAND),
    .W     (RESP_ENTRY_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (handshake),
    .push_data (push_entry),
    .pop       (data_ok),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Read data is only driven while a read response is being retired.
  always_comb begin
    rdata = 32'h0000_0000;
    if (data_ok && head_entry.is_read) begin
      rdata = head_entry.data;
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  assign unused_bits = ^{size, addr, fifo_count};

endmodule

// File: tb/tb_sram_like_responder.sv
module tb_sram_like_responder;

  localparam int OUTSTAND = 2;
  localparam int NV       = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_responder #(
    .MEM_AW   (12),
    .OUTSTAND (OUTSTAND),
    .INIT_FILE("")
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .wstrb   (wstrb),
    .addr    (addr),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata)
  );

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [NV];

  logic [31:0] model [16];
  logic [31:0] expq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req   = r;
    wr    = w;
    wstrb = s;
    addr  = a;
    wdata = d;
    size  = 2'd2;
  endtask

  // One scoreboarded cycle: drive, check handshakes and data, update model.
  task automatic rcycle(input logic r, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, output logic acc);
    logic [3:0]  i;
    logic [31:0] e;
    @(negedge clk);
    drive(r, w, s, a, d);
    #1;
`ifdef SRAM_RAND_DELAY_EN
    if (expq.size() >= OUTSTAND) check("full_blocks_addr_ok", {31'd0, addr_ok}, 32'd0);
    if (expq.size() == 0) check("empty_no_data_ok", {31'd0, data_ok}, 32'd0);
`else
    check("addr_ok_when_room", {31'd0, addr_ok}, {31'd0, expq.size() < OUTSTAND});
    check("data_ok_when_pending", {31'd0, data_ok}, {31'd0, expq.size() != 0});
`endif
    if (data_ok && expq.size() != 0) begin
      e = expq.pop_front();
      check("rand_rdata", rdata, e);
    end
    acc = r && addr_ok;
    if (acc) begin
      i = a[5:2];
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
        end
        expq.push_back(32'h0);
      end else begin
        expq.push_back(model[i]);
      end
    end
  endtask

  initial begin
    logic acc;
    logic [31:0] a;

    //                 req   wr    wstrb  addr           wdata          aok   dok   rdata
    vecs[0]  = '{1'b1, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b1, 4'hF, 32'h0000_2000, 32'h1122_3344, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 4'h4, 32'h0000_2000, 32'h00AB_0000, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h11AB_3344};
    vecs[7]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'hA0A0_A0A0, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'hB1B1_B1B1, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0008, 32'hC2C2_C2C2, 1'b1, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0,         1'b1, 1'b1, 32'hA0A0_A0A0};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0,         1'b1, 1'b1, 32'hB1B1_B1B1};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 32'h0000_4003, 32'h0,         1'b1, 1'b1, 32'hC2C2_C2C2};
    vecs[14] = '{1'b1, 1'b1, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hA0A0_A0A0};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b1, 32'hA0A0_A0A0};
    vecs[17] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset held three cycles, outputs quiet throughout.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst%0d_addr_ok", c), {31'd0, addr_ok}, 32'd0);
      check($sformatf("rst%0d_data_ok", c), {31'd0, data_ok}, 32'd0);
      check($sformatf("rst%0d_rdata", c), rdata, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_addr_ok", {31'd0, addr_ok}, 32'd1);
    check("post_rst_data_ok", {31'd0, data_ok}, 32'd0);

`ifndef SRAM_RAND_DELAY_EN
    // Directed vectors: outputs expected in the same cycle as the inputs.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].wr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("v%0d_addr_ok", i), {31'd0, addr_ok}, {31'd0, vecs[i].e_aok});
      check($sformatf("v%0d_data_ok", i), {31'd0, data_ok}, {31'd0, vecs[i].e_dok});
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
    end

    // Reset while a read response is still pending drops it.
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
    #1;
    check("mid_a_data_ok", {31'd0, data_ok}, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    #1;
    check("mid_b_data_ok", {31'd0, data_ok}, 32'd1);
    check("mid_b_rdata", rdata, 32'hA0A0_A0A0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    check("mid_rst_data_ok", {31'd0, data_ok}, 32'd0);
    check("mid_rst_addr_ok", {31'd0, addr_ok}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_after_data_ok", {31'd0, data_ok}, 32'd0);
    check("mid_after_addr_ok", {31'd0, addr_ok}, 32'd1);
    @(negedge clk);
    #1;
    check("mid_after2_data_ok", {31'd0, data_ok}, 32'd0);
`endif

    // Scoreboard run over a 16-word window at 0x300 (with aliases).
    for (int i = 0; i < 16; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
        rcycle(1'b1, 1'b1, 4'hF, 32'h300 + 32'(i) * 32'd4, $urandom, acc);
      end
      check($sformatf("fill%0d_accepted", i), {31'd0, acc}, 32'd1);
    end
    for (int n = 0; n < 1000; n++) begin
      a = 32'h300 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a + 32'h0000_4000;
      rcycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             4'($urandom_range(0, 15)), a, $urandom, acc);
    end
    for (int t = 0; t < 64 && expq.size() != 0; t++) begin
      rcycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc);
    end
    check("drain_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
